// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_ctrl
//  Description : Coprocessor-0 exception / interrupt controller. Decides when
//                to take an exception or interrupt, records EPC/Cause/SR,
//                serves mfc0/mtc0/eret and supplies the handler and return
//                addresses to fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID    = 32'h2019_1217,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_victim,
  input  logic        bd_victim,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic        eret,
  output logic [31:0] dout,
  output logic        int_req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  localparam logic [4:0] C_REG_SR    = 5'd12;
  localparam logic [4:0] C_REG_CAUSE = 5'd13;
  localparam logic [4:0] C_REG_EPC   = 5'd14;
  localparam logic [4:0] C_REG_PRID  = 5'd15;

  // The FSM state is the architectural EXL bit.
  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    IN_EXC = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        w_exl;
  logic        w_irq;
  logic        w_exc;
  logic        w_sr_wr;
  logic        w_epc_wr;
  logic [31:0] w_epc_target;
  logic        w_unused;

  assign w_exl    = (state_q == IN_EXC);
  assign w_irq    = sr_ie_q & (|(hw_int & sr_im_q));
  assign w_exc    = (exc_code != 5'd0);
  assign int_req  = (state_q == NORMAL) & (w_irq | w_exc) & ~reset;
  assign w_sr_wr  = we & (a2 == C_REG_SR);
  assign w_epc_wr = we & (a2 == C_REG_EPC);

  // A delay-slot victim restarts at its branch; modulo-2^32 wrap is intended.
  assign w_epc_target = (bd_victim ? (pc_victim - 32'd4) : pc_victim) & ~32'd3;

  assign handler_pc = HANDLER;
  assign epc_out    = epc_q;

  // SR bits outside IM/EXL/IE are not stored.
  assign w_unused = &{1'b0, din[31:16], din[9:2]};

  // Next-state: exception entry overrides any same-cycle mtc0/eret.
  always_comb begin
    state_d     = state_q;
    sr_im_d     = sr_im_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (int_req) begin
      state_d     = IN_EXC;
      cause_bd_d  = bd_victim;
      cause_exc_d = w_irq ? 5'd0 : exc_code;
      epc_d       = w_epc_target;
    end else begin
      if (w_sr_wr) begin
        sr_im_d = din[15:10];
        sr_ie_d = din[0];
        state_d = din[1] ? IN_EXC : NORMAL;
      end
      // eret's EXL clear takes precedence over a same-cycle SR write.
      if (eret) begin
        state_d = NORMAL;
      end
      if (w_epc_wr) begin
        epc_d = din & ~32'd3;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NORMAL;
      sr_im_q     <= 6'd0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      sr_im_q     <= sr_im_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // mfc0 read port returns the pre-edge register contents.
  always_comb begin
    dout = 32'd0;
    case (a1)
      C_REG_SR:    dout = {16'd0, sr_im_q, 8'd0, w_exl, sr_ie_q};
      C_REG_CAUSE: dout = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
      C_REG_EPC:   dout = epc_q;
      C_REG_PRID:  dout = PRID;
      default:     dout = 32'd0;
    endcase
  end

endmodule
`default_nettype wire
